// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per frame.
// Hits are answered combinationally in the request cycle. A miss starts a
// two-state fill machine that reads the word through the memory controller
// and tolerates any number of iwait stall cycles.
//
// Ports:
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   imemREN          fetch request from the datapath
//   imemaddr[31:0]   fetch byte address (bits [1:0] ignored)
//   iflush           invalidate every frame and abandon any fill
//   ihit             imemload is valid this cycle
//   imemload[31:0]   instruction word, 0 when ihit is low
//   iREN             read request to the memory controller
//   iaddr[31:0]      word-aligned fill address, 0 when idle
//   iwait            controller stall; low means iload is valid
//   iload[31:0]      RAM read data
module icache_direct #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 30 - IW;

  typedef enum logic [0:0] {StIdle, StMiss} state_e;

  state_e          state_q, state_d;
  logic [29:0]     miss_q, miss_d;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;
  logic          hit_raw;
  logic          fill_en;

  assign req_idx  = imemaddr[IW+1:2];
  assign req_tag  = imemaddr[31:IW+2];
  assign miss_idx = miss_q[IW-1:0];
  assign miss_tag = miss_q[29:IW];
  assign hit_raw  = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d  = state_q;
    miss_d   = miss_q;
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    fill_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ihit = hit_raw & ~iflush;
        if (ihit) begin
          imemload = data_q[req_idx];
        end
        if (imemREN && !hit_raw && !iflush) begin
          miss_d  = imemaddr[31:2];
          state_d = StMiss;
        end
      end
      StMiss: begin
        // iREN comes only from registered state, never from imemaddr.
        iREN  = ~iflush;
        iaddr = {miss_q, 2'b00};
        if (!iwait) begin
          fill_en = ~iflush;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (iflush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (iflush) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q guards them.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the datapath fetch stage and the memory controller's instruction port. Hits return the instruction word combinationally in the request cycle. On a miss, a two-state fill machine requests the word from RAM through the controller and writes it into the selected frame. The memory controller gives data-cache requests priority, so the fill must tolerate arbitrarily long `iwait` stalls.

## Interface
- `SETS`, 16: number of frames, one 32-bit word each; power of two, minimum 2.
- `CLK` in 1: the only clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `imemREN` in 1: fetch request from the datapath.
- `imemaddr` in 32: byte address of the fetch; bits [1:0] are ignored.
- `iflush` in 1: invalidate all frames (halt or self-modifying-code path).
- `ihit` out 1: `imemload` is valid this cycle.
- `imemload` out 32: instruction word; 0 whenever `ihit`=0.
- `iREN` out 1: read request to the memory controller.
- `iaddr` out 32: word-aligned fill address.
- `iwait` in 1: controller stall; 0 means `iload` is valid this cycle.
- `iload` in 32: RAM read data.

## Operation
- Address split with IW = log2(SETS):
  - index = `imemaddr`[IW+1:2]
  - tag = `imemaddr`[31:IW+2] (26 bits for SETS=16)
- Per frame: valid (1), tag, data (32). Valid bits are reset by `nRST`. Tag and data bits have no reset.
- hit_raw = `imemREN` & valid[index] & (tag[index] == tag).
- States:
  - IDLE:
    - `ihit` = hit_raw & !`iflush`; `imemload` = data[index] when `ihit`, else 0.
    - If `imemREN` & !hit_raw & !`iflush`: latch {tag, index} into miss_addr and go to MISS.
  - MISS:
    - `iREN`=1, `iaddr` = {miss_addr, 2'b00}, `ihit`=0.
    - When `iwait`=0: write frame[miss index] with valid=1, the latched tag, and data=`iload`, then return to IDLE.
    - When `iwait`=1: hold in MISS.
- In IDLE, `iREN`=0 and `iaddr`=0.
- A fill always targets the latched address. Changes to `imemaddr` or `imemREN` during MISS (branch or squash) are ignored until the machine returns to IDLE. The new address is then looked up normally and may miss again.
- `iflush`=1 in any state:
  - Clear all valid bits at the next edge.
  - Force the next state to IDLE.
  - Discard any fill in that cycle, even if `iwait`=0.
  - Force `ihit`=0 and `iREN`=0 combinationally in that cycle.
- Reset values:
  - State IDLE, all valid bits 0.
  - `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- Reset mid-MISS abandons the fill immediately. `iREN` drops asynchronously.

## Timing
- Hit: zero latency; `ihit` and `imemload` are valid in the same cycle as `imemREN`.
- Miss, with the request presented at cycle 0:
  - Cycle 0: miss detected, `ihit`=0.
  - Cycle 1 on: `iREN`=1 (registered state, so no combinational path from `imemaddr` to `iREN`).
  - First cycle k ≥ 1 with `iwait`=0: frame written at the end of that cycle.
  - Cycle k+1: IDLE, `ihit`=1 if the request is unchanged.
  - Minimum miss-to-hit is 2 cycles. Each extra `iwait` cycle adds 1.
- `iaddr` and `iREN` stay stable for the whole MISS residency.
- `iflush` has priority over a simultaneous fill or a simultaneous miss detection.
- Conflict misses (same index, different tag) overwrite the frame. There is no replacement choice.

## Test plan
- Reset: assert `nRST`=0 with `imemREN`=1 and `imemaddr`=0x0 -> `ihit`=0, `iREN`=0, `imemload`=0. Release reset -> miss starts at the next cycle.
- Cold miss:
  - Stimulus: `imemaddr`=0x0000_0104, `iwait` high for 3 cycles of MISS, then low with `iload`=0x2002_0001.
  - Required: `iREN`=1 and `iaddr`=0x0000_0104 for 4 cycles; the next cycle gives `ihit`=1 and `imemload`=0x2002_0001.
- Hit: re-fetch 0x104 -> `ihit`=1 in the same cycle and `iREN` stays 0. Fetch 0x106 (same word) -> hit with the same data.
- Conflict:
  - Stimulus: fill 0x004, then fetch 0x044 (same index, tag 1).
  - Required: a miss occurs. After the fill, 0x004 misses again and 0x044 hits.
- Redirect mid-miss: miss on 0x008, change `imemaddr` to 0x200 while `iwait`=1 -> `iaddr` stays 0x008 until the fill completes, then a new miss on 0x200 starts.
- Flush:
  - Assert `iflush` in IDLE after filling 4 frames -> all four subsequent fetches miss.
  - Assert `iflush` in the same cycle that `iwait`=0 during MISS -> no frame is written and the state is IDLE next cycle.
